lbus_mailbox_slave: RTL and testbench
=====================================

Name: lbus_mailbox_slave

Overview:
- Local-bus responder: a slave on the 16-bit strobe/ack local bus driven by the UART bridge master.
- Buffers 16-bit words pushed by a device-side producer (e.g. a temperature/MKO sampler) in a FIFO, which the bus master drains by reading the DATA register.
- Also provides status/control, scratch and ID registers.

Parameters:
- BASE_ADR, 16'h0100, base address; block decodes BASE_ADR..BASE_ADR+3.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 words (16).
- ID_VALUE, 16'hB0A1, constant returned by the ID register.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RESET_  in  1  asynchronous active-low reset.
- Adr_slave_i_lbus  in  16  bus address.
- Dat_slave_io_lbus  inout  16  bus data; driven only during read ack, else Z.
- Stb_slave_i_lbus_  in  1  strobe, active low.
- We_slave_i_lbus_  in  1  write enable, active low (low = write, high = read), valid with strobe.
- Ack_slave_o_lbus  out  1  acknowledge, active high.
- wr_en_i  in  1  device-side push, one word per cycle high.
- wr_data_i  in  16  device-side push data.
- full_o  out  1  FIFO full.
- irq_o  out  1  see Optional Feature (tied 0 when compiled out).

Behaviour:
- Reset (RESET_ low, async):
  - FSM to IDLE; Ack=0; data bus Z.
  - FIFO pointers and count = 0; overflow=0; scratch=16'h0000; full_o=0; irq_o=0.
- Register map (offset from BASE_ADR):
  - 0 STATUS/CTRL
    - Read: {count[7:0] zero-extended to bits 15:8, 5'b0, overflow, full, empty} (bits 2/1/0).
    - Write: bit0=1 flushes FIFO (pointers/count to 0); bit1=1 clears overflow; other bits ignored.
  - 1 DATA
    - Read: returns head word and pops. Read when empty returns 16'h0000, no pop, pointers unchanged.
    - Write: ignored, but still acked.
  - 2 SCRATCH: read/write, 16 bits.
  - 3 ID: read-only ID_VALUE; writes ignored, acked.
- Decode: hit when Stb_=0 and Adr in [BASE_ADR, BASE_ADR+3]. No hit: no Ack, no drive, no side effect.
- Bus FSM:
  - IDLE: on hit -> ACK. On entry, latch address offset and We_, perform the side effect once (pop, write, flush), and register read data.
  - ACK: Ack=1 from the cycle after the strobe is sampled. Dat driven with latched read data when We_ was high. Hold until Stb_=1, then -> IDLE with Ack=0 and bus released the same edge.
  - Latency: Ack asserted exactly 1 cycle after Stb_ first sampled low.
  - A strobe held low across many cycles produces one transaction only.
  - Back-to-back transfers need Stb_ high for at least 1 cycle.
- FIFO:
  - Circular, DEPTH_LOG2-bit pointers wrapping modulo depth; count width DEPTH_LOG2+1.
  - full = (count == 2**DEPTH_LOG2); empty = (count == 0).
  - Push when full: word dropped, overflow set (sticky), count unchanged.
  - Push and pop in the same cycle: both happen, count unchanged. When full, a simultaneous push+pop is accepted (no overflow).
  - Flush and push in the same cycle: flush wins, push dropped, overflow unaffected.
  - Overflow-clear and new overflow in the same cycle: set wins.
- Reset mid-transaction: Ack drops and bus releases immediately (async). After reset the master must re-strobe.

Optional Feature:
- Macro LBUS_MAILBOX_IRQ_EN.
- Defined:
  - Parameter IRQ_LEVEL (default 8).
  - irq_o is registered and = (count >= IRQ_LEVEL) | overflow; updates one cycle after count changes.
  - STATUS bit3 mirrors irq_o.
- Undefined: irq_o tied 0; STATUS bit3 reads 0.

Test Plan:
- Reset, then read offsets 3 and 2 -> 16'hB0A1 and 16'h0000; Ack rises 1 cycle after Stb_ low, Dat Z outside ack.
- Push 3 words 16'h0011/0022/0033 via wr_en_i; read STATUS -> 16'h0300. Read DATA three times -> 0011, 0022, 0033. Fourth DATA read -> 16'h0000 with STATUS=16'h0001.
- Push 17 words -> full_o=1 after the 16th; 17th dropped; STATUS=16'h1006. Write STATUS 16'h0002 -> overflow cleared, STATUS=16'h1002.
- Fill to 16, then push and read DATA in the same cycle -> count stays 16, no overflow, wrap-around order preserved over 40 further words.
- Stb_ low at BASE_ADR+4 or BASE_ADR-1 -> no Ack, Dat stays Z, no state change. Stb_ held low 10 cycles on DATA read -> exactly one pop.
- With LBUS_MAILBOX_IRQ_EN: push 8 words -> irq_o=1 one cycle after the 8th. Read one word -> irq_o=0 the following cycle. Assert RESET_ mid-ack -> Ack=0 and irq_o=0 immediately.

Source files
------------

// File: rtl/lbus_mailbox_slave_if.sv
// Local-bus strobe/ack signal bundle between the UART bridge master
// and a responder; the bidirectional data bus stays a separate port.
interface lbus_mailbox_slave_if;
  logic [15:0] Adr_slave_i_lbus;
  logic        Stb_slave_i_lbus_;
  logic        We_slave_i_lbus_;
  logic        Ack_slave_o_lbus;

  modport master (
    output Adr_slave_i_lbus,
    output Stb_slave_i_lbus_,
    output We_slave_i_lbus_,
    input  Ack_slave_o_lbus
  );

  modport slave (
    input  Adr_slave_i_lbus,
    input  Stb_slave_i_lbus_,
    input  We_slave_i_lbus_,
    output Ack_slave_o_lbus
  );
endinterface

// File: rtl/lbus_mailbox_slave.sv
// Local-bus mailbox: device-side FIFO drained through a DATA register.
// Define LBUS_MAILBOX_IRQ_EN for the count/overflow interrupt.
module lbus_mailbox_slave #(
  parameter logic [15:0] BASE_ADR   = 16'h0100,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] ID_VALUE   = 16'hB0A1
`ifdef LBUS_MAILBOX_IRQ_EN
  ,
  parameter int          IRQ_LEVEL  = 8
`endif
) (
  input  logic                 CLK,
  input  logic                 RESET_,
  lbus_mailbox_slave_if.slave  bus,
  inout  wire  [15:0]          Dat_slave_io_lbus,
  input  logic                 wr_en_i,
  input  logic [15:0]          wr_data_i,
  output logic                 full_o,
  output logic                 irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C =
    (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                state;
  logic                  ack_q;
  logic                  oe_q;
  logic [15:0]           rd_q;
  logic [15:0]           scratch;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovf;

  logic [15:0] off;
  logic        hit, txn, rd, wr;
  logic        empty, full;
  logic        pop, flush, ovf_clr;
  logic        push_req, push_ok, ovf_set;
  logic        irq_bit;
  logic [15:0] status;
  logic [15:0] rd_mux;

  // Unsigned offset wraps, so one range test covers both ends
  assign off   = bus.Adr_slave_i_lbus - BASE_ADR;
  assign hit   = !bus.Stb_slave_i_lbus_ && (off[15:2] == '0);
  assign txn   = (state == IDLE) && hit;
  assign rd    = txn && bus.We_slave_i_lbus_;
  assign wr    = txn && !bus.We_slave_i_lbus_;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);

  assign pop     = rd && (off[1:0] == 2'd1) && !empty;
  assign flush   = wr && (off[1:0] == 2'd0) && Dat_slave_io_lbus[0];
  assign ovf_clr = wr && (off[1:0] == 2'd0) && Dat_slave_io_lbus[1];

  // A pop in the same cycle frees the slot a full push needs
  assign push_req = wr_en_i && !flush;
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign status = {8'(cnt), 4'b0, irq_bit, ovf, full, empty};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      off[1:0] == 2'd0: rd_mux = status;
      off[1:0] == 2'd1: rd_mux = empty ? '0 : mem[rp];
      off[1:0] == 2'd2: rd_mux = scratch;
      off[1:0] == 2'd3: rd_mux = ID_VALUE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state <= IDLE;
      ack_q <= 1'b0;
      oe_q  <= 1'b0;
      rd_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (hit) begin
          state <= ACK;
          ack_q <= 1'b1;
          oe_q  <= bus.We_slave_i_lbus_;
          rd_q  <= rd_mux;
        end
        ACK: if (bus.Stb_slave_i_lbus_) begin
          state <= IDLE;
          ack_q <= 1'b0;
          oe_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ack_slave_o_lbus = ack_q;
  assign Dat_slave_io_lbus = oe_q ? rd_q : 16'hzzzz;

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      scratch <= '0;
    end else if (wr && (off[1:0] == 2'd2)) begin
      scratch <= Dat_slave_io_lbus;
    end
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (flush) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push_ok) wp <= wp + 1'b1;
        if (pop)     rp <= rp + 1'b1;
        if (push_ok && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push_ok) cnt <= cnt - 1'b1;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wp] <= wr_data_i;
  end

  assign full_o = full;

`ifdef LBUS_MAILBOX_IRQ_EN
  logic irq_q;

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) irq_q <= 1'b0;
    else         irq_q <= (int'(cnt) >= IRQ_LEVEL) || ovf;
  end

  assign irq_bit = irq_q;
  assign irq_o   = irq_q;
`else
  assign irq_bit = 1'b0;
  assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_lbus_mailbox_slave.sv
// Scoreboard bench for the local-bus mailbox slave.
// Expected read data is queued at strobe time and popped at ack.
module tb_lbus_mailbox_slave;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 16;
`ifdef LBUS_MAILBOX_IRQ_EN
  localparam int          IRQ_LEVEL = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full;
  logic        irq;
  logic        m_oe = 1'b0;
  logic [15:0] m_d = '0;
  wire  [15:0] dat;

  lbus_mailbox_slave_if bus();

  assign dat = m_oe ? m_d : 16'hzzzz;

  lbus_mailbox_slave dut (
    .CLK               (clk),
    .RESET_            (rst_n),
    .bus               (bus),
    .Dat_slave_io_lbus (dat),
    .wr_en_i           (wr_en),
    .wr_data_i         (wr_data),
    .full_o            (full),
    .irq_o             (irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mq[$];
  logic [15:0] sb_q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_scr = '0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic irq_m;
    irq_m = 1'b0;
`ifdef LBUS_MAILBOX_IRQ_EN
    irq_m = (mq.size() >= IRQ_LEVEL) || m_ovf;
`endif
    return {8'(mq.size()), 4'b0, irq_m, m_ovf,
            mq.size() == DEPTH, mq.size() == 0};
  endfunction

  function automatic void m_push(input logic [15:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  task automatic bus_rd(input string tag, input logic [15:0] a,
                        input bit psh, input logic [15:0] pd,
                        input int hold);
    logic [15:0] o;
    logic [15:0] got;
    o = a - BASE;
    @(negedge clk);
    bus.Adr_slave_i_lbus  = a;
    bus.We_slave_i_lbus_  = 1'b1;
    bus.Stb_slave_i_lbus_ = 1'b0;
    case (o)
      16'd0:   sb_q.push_back(m_status());
      16'd1:   sb_q.push_back(mq.size() != 0 ? mq.pop_front() : 16'h0);
      16'd2:   sb_q.push_back(m_scr);
      default: sb_q.push_back(16'hB0A1);
    endcase
    if (psh) begin
      wr_en   = 1'b1;
      wr_data = pd;
      m_push(pd);
    end
    chk("ack_pre", 16'(bus.Ack_slave_o_lbus), 16'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("ack_lat", 16'(bus.Ack_slave_o_lbus), 16'h1);
    got = dat;
    chk(tag, got, sb_q.pop_front());
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    bus.Stb_slave_i_lbus_ = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_rel", 16'(bus.Ack_slave_o_lbus), 16'h0);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d,
                        input bit psh, input logic [15:0] pd);
    logic [15:0] o;
    o = a - BASE;
    @(negedge clk);
    bus.Adr_slave_i_lbus  = a;
    bus.We_slave_i_lbus_  = 1'b0;
    bus.Stb_slave_i_lbus_ = 1'b0;
    m_oe = 1'b1;
    m_d  = d;
    if (o == 16'd0 && d[1]) m_ovf = 1'b0;
    if (o == 16'd2) m_scr = d;
    if (o == 16'd0 && d[0]) mq.delete();
    else if (psh) m_push(pd);
    if (psh) begin
      wr_en   = 1'b1;
      wr_data = pd;
    end
    chk("wack_pre", 16'(bus.Ack_slave_o_lbus), 16'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("wack_lat", 16'(bus.Ack_slave_o_lbus), 16'h1);
    @(negedge clk);
    bus.Stb_slave_i_lbus_ = 1'b1;
    m_oe = 1'b0;
    @(posedge clk);
    #1;
    chk("wack_rel", 16'(bus.Ack_slave_o_lbus), 16'h0);
  endtask

  task automatic bus_miss(input logic [15:0] a, input logic we_n);
    @(negedge clk);
    bus.Adr_slave_i_lbus  = a;
    bus.We_slave_i_lbus_  = we_n;
    bus.Stb_slave_i_lbus_ = 1'b0;
    m_oe = !we_n;
    m_d  = 16'h0003;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("miss_ack", 16'(bus.Ack_slave_o_lbus), 16'h0);
    end
    @(negedge clk);
    bus.Stb_slave_i_lbus_ = 1'b1;
    m_oe = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    m_push(d);
    @(posedge clk);
    #1;
    chk("full", 16'(full), 16'(mq.size() == DEPTH));
  endtask

  task automatic push_end();
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    bus.Adr_slave_i_lbus  = '0;
    bus.We_slave_i_lbus_  = 1'b1;
    bus.Stb_slave_i_lbus_ = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 16'(bus.Ack_slave_o_lbus), 16'h0);
    chk("rst_full", 16'(full), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    bus_rd("id", BASE + 16'd3, 0, '0, 1);
    bus_rd("scr_rst", BASE + 16'd2, 0, '0, 1);

    push_word(16'h0011);
    push_word(16'h0022);
    push_word(16'h0033);
    push_end();
    bus_rd("stat3", BASE, 0, '0, 1);
    for (int i = 0; i < 4; i++) bus_rd("data", BASE + 16'd1, 0, '0, 1);
    bus_rd("stat_empty", BASE, 0, '0, 1);

    bus_wr(BASE + 16'd2, 16'hA5C3, 0, '0);
    bus_rd("scr", BASE + 16'd2, 0, '0, 1);
    bus_wr(BASE + 16'd3, 16'h1234, 0, '0);
    bus_rd("id_ro", BASE + 16'd3, 0, '0, 1);

    bus_miss(BASE + 16'd4, 1'b1);
    bus_miss(16'h00FF, 1'b0);
    bus_rd("scr_miss", BASE + 16'd2, 0, '0, 1);
    bus_rd("stat_miss", BASE, 0, '0, 1);

    for (int i = 0; i < 17; i++) push_word(16'h1000 + 16'(i));
    push_end();
    bus_rd("stat_ovf", BASE, 0, '0, 1);
    bus_wr(BASE, 16'h0002, 0, '0);
    bus_rd("stat_clr", BASE, 0, '0, 1);
    bus_wr(BASE + 16'd1, 16'hFFFF, 0, '0);
    bus_rd("stat_dwr", BASE, 0, '0, 1);

    for (int i = 0; i < 40; i++)
      bus_rd("wrap", BASE + 16'd1, 1, 16'h2000 + 16'(i), 1);
    bus_rd("stat_wrap", BASE, 0, '0, 1);
    for (int i = 0; i < DEPTH; i++)
      bus_rd("drain", BASE + 16'd1, 0, '0, 1);
    bus_rd("stat_drain", BASE, 0, '0, 1);

    push_word(16'h0A0A);
    push_word(16'h0B0B);
    push_end();
    bus_rd("held", BASE + 16'd1, 0, '0, 10);
    bus_rd("stat_held", BASE, 0, '0, 1);
    bus_rd("held_next", BASE + 16'd1, 0, '0, 1);

    for (int i = 0; i < DEPTH; i++) push_word(16'h3000 + 16'(i));
    push_end();
    bus_wr(BASE, 16'h0002, 1, 16'hDEAD);
    bus_rd("stat_setwin", BASE, 0, '0, 1);
    bus_wr(BASE, 16'h0001, 1, 16'hBEEF);
    bus_rd("stat_flushwin", BASE, 0, '0, 1);
    bus_wr(BASE, 16'h0002, 0, '0);
    bus_rd("stat_final", BASE, 0, '0, 1);

`ifdef LBUS_MAILBOX_IRQ_EN
    for (int i = 0; i < 8; i++) push_word(16'h4000 + 16'(i));
    chk("irq_lag", 16'(irq), 16'h0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("irq_set", 16'(irq), 16'h1);
    bus_rd("irq_pop", BASE + 16'd1, 0, '0, 1);
    chk("irq_clr", 16'(irq), 16'h0);
    push_word(16'h4100);
    push_end();
    #1;
    chk("irq_reset", 16'(irq), 16'h1);
`endif

    @(negedge clk);
    bus.Adr_slave_i_lbus  = BASE + 16'd3;
    bus.We_slave_i_lbus_  = 1'b1;
    bus.Stb_slave_i_lbus_ = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ack", 16'(bus.Ack_slave_o_lbus), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_rst", 16'(bus.Ack_slave_o_lbus), 16'h0);
    chk("mid_irq_rst", 16'(irq), 16'h0);
    chk("mid_full_rst", 16'(full), 16'h0);
    bus.Stb_slave_i_lbus_ = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_scr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd("stat_post", BASE, 0, '0, 1);
    bus_rd("scr_post", BASE + 16'd2, 0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
